i2si_bist_ctrl: RTL and testbench

// Self-test sequencer for the I2S input path. On a start pulse it drains the i2si FIFO, switches the input mux
// to the BIST generator, and consumes a programmed number of samples from the FIFO output. It checks each

---
 rtl/i2si_bist_if.sv | 25 ++
 rtl/i2si_bist_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_i2si_bist_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2si_bist_if.sv
// FIFO-side and filter-side rts/rtr handshake bundle for the i2si BIST controller.
// master = controller view, slave = FIFO/filter environment view.
interface i2si_bist_if;
  logic [31:0] i2si_data;
  logic        i2si_rts;
  logic        i2si_rtr;
  logic        filt_rtr;
  logic        filt_rts;

  modport master (
    input  i2si_data,
    input  i2si_rts,
    input  filt_rtr,
    output i2si_rtr,
    output filt_rts
  );

  modport slave (
    output i2si_data,
    output i2si_rts,
    output filt_rtr,
    input  i2si_rtr,
    input  filt_rts
  );
endinterface

// File: rtl/i2si_bist_ctrl.sv
// I2S input-path self-test: flush FIFO, switch mux to BIST ramp,
// check samples against a ramp model, restore deserializer mode.
module i2si_bist_ctrl #(
  parameter int FLUSH_CYC = 16,
  parameter int TIMEOUT   = 4096,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      rf_bist_start_val,
  input  logic [7:0]       rf_bist_inc,
  input  logic [31:0]      rf_bist_up_limit,
  input  logic [CNT_W-1:0] rf_sample_cnt,
  i2si_bist_if.master      bus,
  output logic             rf_mux_en,
  output logic             i2si_en_gate,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [CNT_W-1:0] err_cnt,
  output logic [31:0]      first_err
);

  localparam int QW = $clog2(FLUSH_CYC + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_SEED,
    S_CHECK,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic [31:0]      r_start;
  logic [7:0]       r_inc;
  logic [31:0]      r_lim;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_nsamp;
  logic [31:0]      r_exp;
  logic [QW-1:0]    r_quiet;
  logic [TW-1:0]    r_tcnt;
  logic             r_mux;
  logic             r_pass;
  logic             r_tmo;
  logic [CNT_W-1:0] r_err;
  logic [31:0]      r_ferr;

  logic        w_take;
  logic        w_qdone;
  logic        w_thit;
  logic        w_seed_bad;
  logic        w_mism;
  logic        w_err_now;
  logic        w_last;
  logic [31:0] w_base;
  logic [32:0] w_sum;
  logic [31:0] w_exp_nx;
  logic        w_rtr;
  logic        w_frts;
  logic        w_gate;
  logic        w_busy;
  logic        w_done;

  // Samples are only consumed into the model while seeding or checking
  assign w_take  = bus.i2si_rts &
                   ((r_state == S_SEED) || (r_state == S_CHECK));
  assign w_qdone = !bus.i2si_rts &&
                   (r_quiet == QW'(FLUSH_CYC - 1));
  assign w_thit  = !w_take && (r_tcnt == TW'(TIMEOUT - 1));

  assign w_seed_bad = (bus.i2si_data < r_start) ||
                      (bus.i2si_data > r_lim);
  assign w_mism     = bus.i2si_data != r_exp;
  assign w_err_now  = w_take &&
                      (((r_state == S_SEED) && w_seed_bad) ||
                       ((r_state == S_CHECK) && w_mism));
  assign w_last     = (r_nsamp + CNT_W'(1)) == r_cnt;

  // A bad seed restarts the ramp at its lower bound
  assign w_base   = (r_state == S_SEED) ?
                    (w_seed_bad ? r_start : bus.i2si_data) : r_exp;
  assign w_sum    = {1'b0, w_base} + {25'd0, r_inc};
  assign w_exp_nx = (w_sum > {1'b0, r_lim}) ? r_start : w_sum[31:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_rtr  = 1'b1;
    w_frts = 1'b0;
    w_gate = 1'b0;
    w_busy = 1'b1;
    w_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_rtr  = bus.filt_rtr;
        w_frts = bus.i2si_rts;
        w_gate = 1'b1;
        w_busy = 1'b0;
        if (start) w_nxt = S_FLUSH;
      end
      S_FLUSH: begin
        if (w_qdone)
          w_nxt = (r_cnt == '0) ? S_RESTORE : S_SEED;
      end
      S_SEED: begin
        if (w_take)
          w_nxt = (r_cnt == CNT_W'(1)) ? S_RESTORE : S_CHECK;
        else if (w_thit)
          w_nxt = S_RESTORE;
      end
      S_CHECK: begin
        if (w_take && w_last) w_nxt = S_RESTORE;
        else if (w_thit)      w_nxt = S_RESTORE;
      end
      S_RESTORE: begin
        if (w_qdone) w_nxt = S_DONE;
      end
      S_DONE: begin
        w_rtr  = 1'b0;
        w_gate = 1'b1;
        w_busy = 1'b0;
        w_done = 1'b1;
        w_nxt  = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start <= '0;
      r_inc   <= '0;
      r_lim   <= '0;
      r_cnt   <= '0;
      r_nsamp <= '0;
      r_exp   <= '0;
      r_quiet <= '0;
      r_tcnt  <= '0;
      r_mux   <= 1'b0;
      r_pass  <= 1'b0;
      r_tmo   <= 1'b0;
      r_err   <= '0;
      r_ferr  <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_start <= rf_bist_start_val;
        r_inc   <= rf_bist_inc;
        r_lim   <= rf_bist_up_limit;
        r_cnt   <= rf_sample_cnt;
        r_err   <= '0;
        r_ferr  <= '0;
        r_tmo   <= 1'b0;
      end
      if ((w_nxt != r_state) || bus.i2si_rts) r_quiet <= '0;
      else r_quiet <= r_quiet + QW'(1);
      if ((w_nxt != r_state) || w_take) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + TW'(1);
      if (r_state == S_FLUSH && w_nxt == S_SEED) r_mux <= 1'b1;
      else if (w_nxt == S_RESTORE)               r_mux <= 1'b0;
      if (w_take) begin
        r_exp   <= w_exp_nx;
        r_nsamp <= (r_state == S_SEED) ? CNT_W'(1) :
                   r_nsamp + CNT_W'(1);
      end
      if (w_err_now) begin
        if (r_err != '1) r_err  <= r_err + CNT_W'(1);
        if (r_err == '0) r_ferr <= bus.i2si_data;
      end
      if ((r_state == S_SEED || r_state == S_CHECK) && w_thit)
        r_tmo <= 1'b1;
      if (r_state == S_RESTORE && w_qdone)
        r_pass <= (r_err == '0) && !r_tmo;
    end
  end

  assign bus.i2si_rtr = w_rtr;
  assign bus.filt_rts = w_frts;
  assign rf_mux_en    = r_mux;
  assign i2si_en_gate = w_gate;
  assign busy         = w_busy;
  assign done         = w_done;
  assign pass         = r_pass;
  assign timeout      = r_tmo;
  assign err_cnt      = r_err;
  assign first_err    = r_ferr;

endmodule

// File: tb/tb_i2si_bist_ctrl.sv
// Randomized self-checking bench for i2si_bist_ctrl against a
// queue-based ramp reference model.
module tb_i2si_bist_ctrl;
  localparam int CNT_W = 16;
  localparam int TMO   = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [31:0]      sv_i;
  logic [7:0]       inc_i;
  logic [31:0]      lim_i;
  logic [CNT_W-1:0] cnt_i;
  logic             mux_en, gate, busy, done, pass, tmo;
  logic [CNT_W-1:0] err;
  logic [31:0]      ferr;

  i2si_bist_if bus();

  i2si_bist_ctrl #(.FLUSH_CYC(16), .TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rf_bist_start_val(sv_i), .rf_bist_inc(inc_i),
    .rf_bist_up_limit(lim_i), .rf_sample_cnt(cnt_i),
    .bus(bus),
    .rf_mux_en(mux_en), .i2si_en_gate(gate), .busy(busy),
    .done(done), .pass(pass), .timeout(tmo),
    .err_cnt(err), .first_err(ferr)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int leak = 0;
  int rtrlow = 0;
  logic [31:0] stim[$];

  always @(negedge clk) begin
    if (busy && bus.filt_rts) leak++;
    if (busy && !bus.i2si_rtr) rtrlow++;
  end

  // Ideal ramp from a given seed
  function automatic void gen(input longint s0, input longint inc,
                              input longint lim, input longint seed,
                              input int n);
    longint e;
    stim.delete();
    e = seed;
    for (int i = 0; i < n; i++) begin
      stim.push_back(e[31:0]);
      e = (e + inc > lim) ? s0 : e + inc;
    end
  endfunction

  // Reference: walk the received stream against the ramp rules
  function automatic void model(input longint s0, input longint inc,
                                input longint lim, output int errs,
                                output logic [31:0] fe);
    longint e;
    longint s;
    bit bad;
    errs = 0;
    fe = 0;
    e = s0;
    foreach (stim[i]) begin
      s = longint'(stim[i]);
      if (i == 0) begin
        bad = (s < s0) || (s > lim);
        e = bad ? s0 : s;
      end else begin
        bad = (s != e);
      end
      if (bad) begin
        if (errs == 0) fe = stim[i];
        errs++;
      end
      e = (e + inc > lim) ? s0 : e + inc;
    end
  endfunction

  task automatic run_test(input logic [31:0] s0, input logic [7:0] inc,
                          input logic [31:0] lim, input logic [15:0] cnt,
                          input int maxgap, input int stale,
                          output bit got_done, output bit mux_seen,
                          output bit mux_after, output bit o_pass,
                          output bit o_tmo, output int o_err,
                          output logic [31:0] o_ferr);
    sv_i = s0; inc_i = inc; lim_i = lim; cnt_i = cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sv_i = $urandom; inc_i = 8'($urandom);
    lim_i = $urandom; cnt_i = 16'($urandom);
    repeat (stale) begin
      bus.i2si_data = $urandom;
      @(negedge clk);
    end
    bus.i2si_rts = 1'b0;
    mux_seen = 1'b0;
    if (cnt != 0) begin
      for (int i = 0; i < 100; i++) begin
        if (mux_en) begin
          mux_seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
    end
    foreach (stim[i]) begin
      repeat ($urandom_range(0, maxgap)) begin
        bus.i2si_rts = 1'b0;
        bus.i2si_data = $urandom;
        @(negedge clk);
      end
      bus.i2si_rts = 1'b1;
      bus.i2si_data = stim[i];
      @(negedge clk);
    end
    bus.i2si_rts = 1'b0;
    mux_after = mux_en;
    got_done = 1'b0;
    for (int i = 0; i < TMO + 200; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    o_pass = pass; o_tmo = tmo; o_err = int'(err); o_ferr = ferr;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (mux_en !== 1'b0) $display("FAIL rst_mux got %b want 0", mux_en); else n_pass++;
    n_chk++; if (gate !== 1'b1) $display("FAIL rst_gate got %b want 1", gate); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL rst_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL rst_done got %b want 0", done); else n_pass++;
    n_chk++; if (pass !== 1'b0) $display("FAIL rst_pass got %b want 0", pass); else n_pass++;
    n_chk++; if (tmo !== 1'b0) $display("FAIL rst_tmo got %b want 0", tmo); else n_pass++;
    n_chk++; if (err !== '0) $display("FAIL rst_err got %h want 0", err); else n_pass++;
    n_chk++; if (ferr !== '0) $display("FAIL rst_ferr got %h want 0", ferr); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_clean_ramp;
    bit d, ms, ma, p, t;
    int e;
    logic [31:0] f;
    gen(0, 1, 'hFF, 'h10, 8);
    run_test(0, 1, 'hFF, 8, 2, 0, d, ms, ma, p, t, e, f);
    n_chk++; if (d !== 1'b1) $display("FAIL clean_done got %b want 1", d); else n_pass++;
    n_chk++; if (ms !== 1'b1) $display("FAIL clean_mux_on got %b want 1", ms); else n_pass++;
    n_chk++; if (ma !== 1'b0) $display("FAIL clean_mux_off got %b want 0", ma); else n_pass++;
    n_chk++; if (p !== 1'b1) $display("FAIL clean_pass got %b want 1", p); else n_pass++;
    n_chk++; if (e !== 0) $display("FAIL clean_err got %0d want 0", e); else n_pass++;
    n_chk++; if (t !== 1'b0) $display("FAIL clean_tmo got %b want 0", t); else n_pass++;
    n_chk++; if (done !== 1'b0) $display("FAIL clean_pulse got %b want 0", done); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL clean_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_wrap;
    bit d, ms, ma, p, t;
    int e, xe;
    logic [31:0] f, xf;
    stim.delete();
    stim.push_back('h11); stim.push_back('h12);
    stim.push_back('h10); stim.push_back('h11);
    model('h10, 1, 'h12, xe, xf);
    run_test('h10, 1, 'h12, 4, 1, 0, d, ms, ma, p, t, e, f);
    n_chk++; if (d !== 1'b1) $display("FAIL wrap_done got %b want 1", d); else n_pass++;
    n_chk++; if (e !== xe) $display("FAIL wrap_err got %0d want %0d", e, xe); else n_pass++;
    n_chk++; if (p !== (xe == 0)) $display("FAIL wrap_pass got %b want %b", p, xe == 0); else n_pass++;
  endtask

  task automatic test_corrupt;
    bit d, ms, ma, p, t;
    int e, xe;
    logic [31:0] f, xf;
    gen('h10, 1, 'hFF, 'h10, 6);
    stim[2] = 32'hDEAD;
    model('h10, 1, 'hFF, xe, xf);
    run_test('h10, 1, 'hFF, 6, 2, 0, d, ms, ma, p, t, e, f);
    n_chk++; if (e !== xe) $display("FAIL corr_err got %0d want %0d", e, xe); else n_pass++;
    n_chk++; if (f !== xf) $display("FAIL corr_ferr got %h want %h", f, xf); else n_pass++;
    n_chk++; if (p !== 1'b0) $display("FAIL corr_pass got %b want 0", p); else n_pass++;
  endtask

  task automatic test_random;
    bit d, ms, ma, p, t;
    int e, xe, n;
    logic [31:0] f, xf, s0, lim;
    logic [7:0] inc;
    for (int it = 0; it < 8; it++) begin
      s0  = $urandom_range(0, 1000);
      lim = s0 + $urandom_range(0, 300);
      inc = 8'($urandom_range(0, 255));
      n   = $urandom_range(1, 20);
      gen(s0, inc, lim, s0 + $urandom_range(0, lim - s0), n);
      if ($urandom_range(0, 3) == 0) stim[0] = lim + 5;
      foreach (stim[i])
        if ($urandom_range(0, 5) == 0) stim[i] = $urandom;
      model(s0, inc, lim, xe, xf);
      run_test(s0, inc, lim, 16'(n), 3, 0, d, ms, ma, p, t, e, f);
      n_chk++; if (d !== 1'b1) $display("FAIL rnd%0d_done got %b want 1", it, d); else n_pass++;
      n_chk++; if (e !== xe) $display("FAIL rnd%0d_err got %0d want %0d", it, e, xe); else n_pass++;
      n_chk++; if (f !== xf) $display("FAIL rnd%0d_ferr got %h want %h", it, f, xf); else n_pass++;
      n_chk++; if (p !== (xe == 0)) $display("FAIL rnd%0d_pass got %b want %b", it, p, xe == 0); else n_pass++;
      n_chk++; if (ma !== 1'b0) $display("FAIL rnd%0d_mux got %b want 0", it, ma); else n_pass++;
    end
  endtask

  task automatic test_timeout;
    bit d, ms, ma, p, t;
    int e;
    logic [31:0] f;
    stim.delete();
    run_test(0, 1, 'hFF, 4, 0, 0, d, ms, ma, p, t, e, f);
    n_chk++; if (d !== 1'b1) $display("FAIL tmo_done got %b want 1", d); else n_pass++;
    n_chk++; if (ms !== 1'b1) $display("FAIL tmo_mux got %b want 1", ms); else n_pass++;
    n_chk++; if (t !== 1'b1) $display("FAIL tmo_flag got %b want 1", t); else n_pass++;
    n_chk++; if (p !== 1'b0) $display("FAIL tmo_pass got %b want 0", p); else n_pass++;
    n_chk++; if (e !== 0) $display("FAIL tmo_err got %0d want 0", e); else n_pass++;
  endtask

  task automatic test_stale;
    bit d, ms, ma, p, t;
    int e;
    logic [31:0] f;
    stim.delete();
    leak = 0;
    rtrlow = 0;
    bus.filt_rtr = 1'b0;
    bus.i2si_rts = 1'b1;
    bus.i2si_data = 32'hBAD0;
    @(negedge clk);
    run_test(0, 1, 'hFF, 0, 0, 6, d, ms, ma, p, t, e, f);
    n_chk++; if (d !== 1'b1) $display("FAIL stale_done got %b want 1", d); else n_pass++;
    n_chk++; if (p !== 1'b1) $display("FAIL stale_pass got %b want 1", p); else n_pass++;
    n_chk++; if (leak !== 0) $display("FAIL stale_frts got %0d want 0", leak); else n_pass++;
    n_chk++; if (rtrlow !== 0) $display("FAIL stale_rtr got %0d want 0", rtrlow); else n_pass++;
    bus.i2si_rts = 1'b1;
    bus.filt_rtr = 1'b1;
    #1;
    n_chk++; if (bus.filt_rts !== 1'b1) $display("FAIL pt_frts got %b want 1", bus.filt_rts); else n_pass++;
    n_chk++; if (bus.i2si_rtr !== 1'b1) $display("FAIL pt_rtr1 got %b want 1", bus.i2si_rtr); else n_pass++;
    bus.filt_rtr = 1'b0;
    #1;
    n_chk++; if (bus.i2si_rtr !== 1'b0) $display("FAIL pt_rtr0 got %b want 0", bus.i2si_rtr); else n_pass++;
    n_chk++; if (gate !== 1'b1) $display("FAIL pt_gate got %b want 1", gate); else n_pass++;
    bus.i2si_rts = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid;
    bit d, ms, ma, p, t;
    int e;
    logic [31:0] f;
    gen('h20, 2, 'hFF, 'h20, 8);
    sv_i = 'h20; inc_i = 2; lim_i = 'hFF; cnt_i = 8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !mux_en; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.i2si_rts = 1'b1;
      bus.i2si_data = (i == 1) ? 32'h5A5A : stim[i];
      @(negedge clk);
    end
    bus.i2si_rts = 1'b0;
    n_chk++; if (err !== 16'd1) $display("FAIL mid_err got %0d want 1", err); else n_pass++;
    n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy got %b want 1", busy); else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_chk++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else n_pass++;
    n_chk++; if (mux_en !== 1'b0) $display("FAIL rmid_mux got %b want 0", mux_en); else n_pass++;
    n_chk++; if (err !== '0) $display("FAIL rmid_err got %0d want 0", err); else n_pass++;
    n_chk++; if (gate !== 1'b1) $display("FAIL rmid_gate got %b want 1", gate); else n_pass++;
    @(negedge clk);
    run_test('h20, 2, 'hFF, 8, 2, 0, d, ms, ma, p, t, e, f);
    n_chk++; if (d !== 1'b1) $display("FAIL again_done got %b want 1", d); else n_pass++;
    n_chk++; if (p !== 1'b1) $display("FAIL again_pass got %b want 1", p); else n_pass++;
    n_chk++; if (e !== 0) $display("FAIL again_err got %0d want 0", e); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    sv_i = '0; inc_i = '0; lim_i = '0; cnt_i = '0;
    bus.i2si_data = '0;
    bus.i2si_rts = 1'b0;
    bus.filt_rtr = 1'b0;
    test_reset();
    test_clean_ramp();
    test_wrap();
    test_corrupt();
    test_random();
    test_timeout();
    test_stale();
    test_rst_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
